data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored.
REQ-002 Parameter ADDR_W, default 8: word-index width, equal to log2(DEPTH).
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted per access, range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 MemoryAddress  input  32  byte address from the MEM stage.
REQ-007 MemRD  input  1  read request, held until Ready is seen.
REQ-008 MemWD  input  1  write request, held until Ready is seen.
REQ-009 DataIn  input  32  write data.
REQ-010 DataOut  output  32  registered read data.
REQ-011 Ready  output  1  registered one-cycle completion strobe.
REQ-012 Busy  output  1  high while an access is in progress (stall request to the pipeline).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014 In IDLE, with MemRD or MemWD high, the block SHALL latch address, DataIn and request type at the clock edge: it goes to WAIT with counter = WAIT_CYCLES-1, or directly to DONE when WAIT_CYCLES = 0.
REQ-015 In WAIT, the counter SHALL decrement once per cycle; when it is 0, the FSM goes to DONE.
REQ-016 On entry to DONE, a latched write SHALL update word MemoryAddress[ADDR_W+1:2], and a latched read SHALL load that word into DataOut.
REQ-017 Ready SHALL be high exactly in DONE; DONE SHALL always go to IDLE on the next edge.
REQ-018 Latency: with a request first visible in cycle 0, Ready SHALL be high in cycle WAIT_CYCLES+1.
REQ-019 Busy SHALL be high in WAIT and DONE, and also in IDLE whenever a request is present (combinational), so the requester stalls from cycle 0.
REQ-020 Changes to inputs after acceptance SHALL be ignored until the next IDLE.
REQ-021 MemRD and MemWD both high SHALL be treated as a write; DataOut stays unchanged.
REQ-022 Address bits [1:0] and bits above ADDR_W+1 SHALL be ignored, so addresses alias modulo DEPTH words.
REQ-023 DataOut SHALL hold its value between reads, including across writes.
REQ-024 A request still high in the IDLE cycle after Ready SHALL be accepted as a new request; the requester drops it at the edge where it samples Ready.

Reset
REQ-025 Reset SHALL asynchronously force: state IDLE, counter 0, DataOut 0, Ready 0.
REQ-026 Reset during WAIT SHALL abort the access; the pending write SHALL NOT be performed.
REQ-027 Storage contents SHALL NOT be cleared by Reset.

Configuration
REQ-028 Macro DMEM_WAIT_STATES_EN defined: wait-state behaviour follows WAIT_CYCLES.
REQ-029 Macro DMEM_WAIT_STATES_EN undefined: WAIT state and counter SHALL be compiled out, and every access SHALL behave as WAIT_CYCLES = 0 (Ready in cycle 1).

Structure
REQ-030 A shared package dmem_pkg SHALL hold the state type (IDLE/WAIT/DONE), default DEPTH/ADDR_W/WAIT_CYCLES constants, and the 32-bit word width.
REQ-031 Storage SHALL be a sub-module, dmem_array: synchronous write, registered read, one port, DEPTH x 32.

Verification
REQ-032 Write 0xDEADBEEF to 0x10, then read 0x10 -> Ready in cycle 3 of each access, and DataOut = 0xDEADBEEF.
REQ-033 Read 0x10 then 0x410 (aliases at DEPTH=256) -> both return the same word; bits [1:0] = 3 gives the same result.
REQ-034 MemRD and MemWD both high, DataIn = 0x1234, address 0x20 -> word 0x20 = 0x1234, DataOut unchanged.
REQ-035 Reset asserted in cycle 1 of a write to 0x30 -> Ready never pulses, Busy drops, and a later read of 0x30 returns the old value.
REQ-036 Build without DMEM_WAIT_STATES_EN and issue back-to-back reads -> Ready in cycle 1 of each, and Busy high only during the request and DONE cycles.
REQ-037 Change address/DataIn during WAIT -> the access uses the values latched at acceptance.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word width, default sizing,
// FSM state type and the wait-counter load helper.
package dmem_pkg;

  localparam int unsigned WordW         = 32;
  localparam int unsigned DefDepth      = 256;
  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefWaitCycles = 2;

  // Wait-state counter holds 0..15.
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  // Counter load on acceptance: the WAIT state is held for 'cycles' clocks.
  function automatic logic [CntW-1:0] wait_init(input int unsigned cycles);
    if (cycles == 0) begin
      return '0;
    end
    return CntW'(cycles - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 storage: synchronous write, registered read.
// The read register holds its value until the next read and clears on reset;
// the storage itself is never cleared.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WordW-1:0]  i_wdata,
  output logic [WordW-1:0]  o_rdata
);

  logic [WordW-1:0] r_mem [DEPTH];
  logic [WordW-1:0] r_rdata;

  // Storage write port, no reset so contents survive Reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read data, updated only by reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts a held read/write request,
// inserts wait states, performs the access on entry to DONE and strobes Ready.
// Build option: define DMEM_WAIT_STATES_EN to honour WAIT_CYCLES; without it the
// WAIT state and counter are compiled out and every access is zero-wait.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [31:0]      MemoryAddress,
  input  logic             MemRD,
  input  logic             MemWD,
  input  logic [WordW-1:0] DataIn,
  output logic [WordW-1:0] DataOut,
  output logic             Ready,
  output logic             Busy
);

`ifdef DMEM_WAIT_STATES_EN
  localparam int unsigned EffWait = WAIT_CYCLES;
`else
  // Wait states compiled out: every access behaves as zero-wait.
  localparam int unsigned EffWait = WAIT_CYCLES * 0;
`endif
  localparam bit DirectDone = (EffWait == 0);

  state_e             r_state;
  logic               r_ready;
  logic               r_write;
  logic [ADDR_W-1:0]  r_idx;
  logic [WordW-1:0]   r_wdata;
`ifdef DMEM_WAIT_STATES_EN
  localparam logic [CntW-1:0] WaitInit = wait_init(EffWait);
  logic [CntW-1:0]    r_cnt;
`endif

  logic               w_req;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_fire;
  logic               w_fire_write;
  logic [ADDR_W-1:0]  w_fire_idx;
  logic [WordW-1:0]   w_fire_wdata;
  logic               w_unused_addr;

  assign w_req         = MemRD | MemWD;
  assign w_idx         = MemoryAddress[ADDR_W+1:2];
  // Byte offset and bits above the word index alias away.
  assign w_unused_addr = ^{MemoryAddress[31:ADDR_W+2], MemoryAddress[1:0]};

  // Pick the access that hits storage at this edge (the edge entering DONE).
  always_comb begin
    w_fire       = 1'b0;
    w_fire_write = r_write;
    w_fire_idx   = r_idx;
    w_fire_wdata = r_wdata;
    unique case (r_state)
      StIdle: begin
        // Zero-wait: the latch edge is also the DONE-entry edge, so use live inputs.
        if (w_req && DirectDone) begin
          w_fire       = 1'b1;
          w_fire_write = MemWD;
          w_fire_idx   = w_idx;
          w_fire_wdata = DataIn;
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      StWait: begin
        if (r_cnt == '0) begin
          w_fire = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Control FSM with registered Ready; Reset aborts any pending access.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
`ifdef DMEM_WAIT_STATES_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_ready <= w_fire;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            // Both strobes high is a write.
            r_write <= MemWD;
            r_idx   <= w_idx;
            r_wdata <= DataIn;
`ifdef DMEM_WAIT_STATES_EN
            if (DirectDone) begin
              r_state <= StDone;
            end else begin
              r_state <= StWait;
              r_cnt   <= WaitInit;
            end
`else
            r_state <= StDone;
`endif
          end
        end
`ifdef DMEM_WAIT_STATES_EN
        StWait: begin
          if (r_cnt == '0) begin
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (clk),
    .i_rst   (Reset),
    .i_we    (w_fire & w_fire_write & ~Reset),
    .i_re    (w_fire & ~w_fire_write & ~Reset),
    .i_addr  (w_fire_idx),
    .i_wdata (w_fire_wdata),
    .o_rdata (DataOut)
  );

  assign Ready = r_ready;
  // Stall the requester from the very cycle it raises a request.
  assign Busy  = (r_state != StIdle) | w_req;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses,
// checked against a word-array reference model.
module tb_data_mem_responder;

`ifdef DMEM_WAIT_STATES_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] MemoryAddress;
  logic        MemRD;
  logic        MemWD;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Busy;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_mem [256];
  logic [31:0] exp_dout;

  data_mem_responder #(
    .DEPTH       (256),
    .ADDR_W      (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .MemoryAddress (MemoryAddress),
    .MemRD         (MemRD),
    .MemWD         (MemWD),
    .DataIn        (DataIn),
    .DataOut       (DataOut),
    .Ready         (Ready),
    .Busy          (Busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge leaving DONE.
  task automatic access(input bit rd, input bit wd, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble);
    int   cyc;
    bit   seen;
    bit   busy_ok;
    logic [7:0] idx;
    idx = addr[9:2];
    MemRD = rd;
    MemWD = wd;
    MemoryAddress = addr;
    DataIn = data;
    if (wd) exp_mem[idx] = data;
    else    exp_dout = exp_mem[idx];
    cyc = 0;
    seen = 0;
    busy_ok = 1;
    @(negedge clk);
    while (cyc < 20) begin
      if (Ready) begin
        seen = 1;
        break;
      end
      if (!Busy) busy_ok = 0;
      @(posedge clk);
      #1;
      cyc++;
      if (scramble) begin
        MemoryAddress = $urandom;
        DataIn = $urandom;
      end
      @(negedge clk);
    end
    check_eq("ready_seen", 32'(seen), 32'd1);
    check_eq("latency", cyc, Lat + 1);
    check_eq("busy_wait", 32'(busy_ok), 32'd1);
    check_eq("busy_done", 32'(Busy), 32'd1);
    check_eq("dout", DataOut, exp_dout);
    @(posedge clk);
    #1;
    MemRD = 1'b0;
    MemWD = 1'b0;
    #1;
    check_eq("busy_idle", 32'(Busy), 32'd0);
    check_eq("ready_idle", 32'(Ready), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ready_hit;
    logic [31:0] old30;
    Reset = 1'b1;
    MemRD = 1'b0;
    MemWD = 1'b0;
    MemoryAddress = '0;
    DataIn = '0;
    exp_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dout", DataOut, 32'd0);
    check_eq("rst_ready", 32'(Ready), 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < 256; i++) begin
      access(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);
    end

    // Write then read back.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    check_eq("deadbeef", DataOut, 32'hDEADBEEF);

    // Aliasing and ignored byte offset, issued back-to-back.
    access(1'b1, 1'b0, 32'h410, 32'h0, 1'b0);
    check_eq("alias_410", DataOut, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h413, 32'h0, 1'b0);
    check_eq("alias_413", DataOut, 32'hDEADBEEF);

    // Both strobes high acts as a write and leaves DataOut alone.
    access(1'b1, 1'b1, 32'h20, 32'h1234, 1'b0);
    check_eq("both_hold", DataOut, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check_eq("both_word", DataOut, 32'h1234);

    // Inputs changing after acceptance are ignored.
    access(1'b0, 1'b1, 32'h40, 32'hA5A5_0F0F, 1'b1);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    check_eq("latched", DataOut, 32'hA5A5_0F0F);

    // Reset in cycle 1 of a write to 0x30.
    old30 = exp_mem[8'h0C];
    MemWD = 1'b1;
    MemoryAddress = 32'h30;
    DataIn = ~old30;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    MemWD = 1'b0;
    ready_hit = 0;
    @(negedge clk);
    check_eq("rst_mid_busy", 32'(Busy), 32'd0);
    check_eq("rst_mid_dout", DataOut, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (Ready) ready_hit = 1;
      @(negedge clk);
    end
    check_eq("rst_mid_ready", 32'(ready_hit), 32'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    exp_dout = '0;
    // Zero-wait builds have already written by cycle 1.
    if (Lat == 0) exp_mem[8'h0C] = ~old30;
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
